pio_in_capture: RTL
===================

PIO_IN_CAPTURE -- requirements
Module: pio_in_capture

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 8, input port width, legal 1..32.
- SYNC_STAGES, 2, synchroniser depth, legal 2..3.
- EDGE_TYPE, 0, edge sense: 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 4, debounce stable-count, legal 1..255; used only with PIO_IN_CAPTURE_DEBOUNCE_EN.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- reset_n, in, 1, reset; asynchronous, active-low.
- address, in, 2, Avalon-MM slave word address.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write strobe.
- writedata, in, 32, write data.
- in_port, in, WIDTH, asynchronous external inputs.
- readdata, out, 32, registered read data.
- irq, out, 1, level interrupt.

Function
REQ-003 in_port SHALL pass through a SYNC_STAGES-deep flop chain per bit; the result is "sync".

REQ-004 Register map SHALL be:
- 0: data, read-only, returns "stable".
- 1: reserved, reads 0.
- 2: irqmask, R/W, WIDTH bits.
- 3: edgecapture, read; write-1-to-clear.

REQ-005 readdata SHALL be registered every clk from the current address, irrespective of chipselect. Read latency is 1 cycle. Bits [31:WIDTH] SHALL read 0.

REQ-006 A write SHALL occur when chipselect=1 and write_n=0. Writes to addresses 0 and 1 SHALL be ignored.

REQ-007 Edge detection SHALL compare "stable" with a one-cycle-delayed copy "prev":
- rising: stable & ~prev.
- falling: ~stable & prev.
- any: stable ^ prev.

REQ-008 A detected edge SHALL set the corresponding edgecapture bit on the next clk. The bit SHALL remain set until cleared.

REQ-009 Writing address 3 SHALL clear each edgecapture bit whose writedata bit is 1. If an edge and a clear hit the same bit in the same cycle, the set SHALL win.

REQ-010 irq SHALL equal OR-reduce(edgecapture & irqmask), driven combinationally from registers with no additional latency.

REQ-011 An arm counter SHALL block edge detection after reset:
- Counts 0..SYNC_STAGES+1, then saturates.
- Edge detection is enabled only at saturation.
- Purpose: no spurious edge from a pin already high or low at reset release.

REQ-012 A readdata sample SHALL reflect edgecapture as it was before any same-cycle update.

Reset
REQ-013 While reset_n=0, the following SHALL be 0: readdata, irq, irqmask, edgecapture, sync chain, stable, prev, arm counter, and all debounce counters.

REQ-014 Reset assertion mid-operation SHALL immediately discard pending edges and debounce progress. After release, the arm sequence of REQ-011 SHALL restart.

Configuration
REQ-015 With macro PIO_IN_CAPTURE_DEBOUNCE_EN defined, each bit SHALL have an 8-bit debounce counter:
- Counter increments while sync differs from stable.
- Counter resets to 0 the cycle sync equals stable.
- When the counter reaches DEBOUNCE_CYCLES, stable takes the sync value and the counter resets.

REQ-016 Without PIO_IN_CAPTURE_DEBOUNCE_EN, stable SHALL equal sync directly, with no added latency. No debounce logic SHALL be synthesised.

Verification
REQ-017 A bench SHALL cover these directed scenarios (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0 unless stated):
- Reset with in_port=8'hFF, release, wait 10 clk -> edgecapture=0, irq=0; read addr 0 -> 32'h000000FF one cycle after address.
- irqmask=8'h04; in_port bit2 0->1 -> edgecapture=8'h04, irq=1. Write 32'h04 to addr 3 -> irq=0 next cycle.
- EDGE_TYPE=2: toggle bit0 twice -> edgecapture bit0 set after the first toggle and still set after the second. Same-cycle clear and new edge -> bit remains 1.
- Debounce on, DEBOUNCE_CYCLES=4: glitch bit1 high for 3 cycles -> stable unchanged, no edge. Hold high 6 cycles -> stable bit1=1, edgecapture=8'h02.
- Assert reset_n low while edgecapture=8'h0F and irq=1 -> edgecapture=0 and irq=0 immediately. No edge for 3 clk after release.
- Write addr 0 with 32'hFFFFFFFF -> data readback unaffected; readdata[31:8]=0.

Source files
------------

// File: rtl/pio_in_capture.sv
// pio_in_capture: Avalon-MM parallel input port with synchroniser, edge capture and irq.
// Define PIO_IN_CAPTURE_DEBOUNCE_EN to add a per-bit debounce filter ahead of edge detection.
module pio_in_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [2:0]       arm_q, arm_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             armed;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_CAPTURE_DEBOUNCE_EN
  logic [WIDTH-1:0][7:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      stable_q, stable_d;

  // A bit only moves once sync has disagreed for DEBOUNCE_CYCLES in a row.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync[i] == stable_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] + 8'd1 == 8'(DEBOUNCE_CYCLES)) begin
        stable_d[i] = sync[i];
        cnt_d[i]    = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
`else
  logic [7:0] unused_db;

  assign unused_db = 8'(DEBOUNCE_CYCLES);
  assign stable    = sync;
`endif

  assign armed = (arm_q == ARM_MAX);
  assign wr_en = chipselect && !write_n;

  always_comb begin
    arm_d = armed ? arm_q : arm_q + 3'd1;
  end

  always_comb begin
    edge_det = '0;
    if (armed) begin
      if (EDGE_TYPE == 0) begin
        edge_det = stable & ~prev_q;
      end else if (EDGE_TYPE == 1) begin
        edge_det = ~stable & prev_q;
      end else begin
        edge_det = stable ^ prev_q;
      end
    end
  end

  assign prev_d = stable;

  // Set is OR'd in after the clear so a same-cycle edge wins.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en) begin
      unique case (1'b1)
        (address == 2'd2): irqmask_d = writedata[WIDTH-1:0];
        (address == 2'd3): edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    edgecap_d = edgecap_d | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      arm_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      arm_q      <= arm_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
